// File: rtl/imm_gen_stage.sv
// RISC-V immediate decode stage behind a 2-entry skid buffer (output register + skid register).
// Optional: define IMM_GEN_STATS_EN to add the illegal_cnt output-handshake counter.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target
`ifdef IMM_GEN_STATS_EN
    ,
    output logic [31:0]     illegal_cnt
`endif
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
    } entry_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    fmt_e            w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic            w_is_shift;
    entry_t          w_entry;
    logic            w_accept;
    logic            w_out_load;

    entry_t          r_out;
    entry_t          r_skid;
    logic            r_out_valid;
    logic            r_skid_valid;
    logic            r_in_ready;

    assign w_is_shift = (in_inst[14:12] == 3'b001) || (in_inst[14:12] == 3'b101);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        w_imm     = '0;
        case (in_inst[6:0])
            OP_IMM: begin
                w_fmt = FMT_I;
                if (w_is_shift) begin
                    // Shift immediates are an unsigned shamt; RV64 widens it by one bit.
                    if (XLEN == 64) w_imm = {{(XLEN-6){1'b0}}, in_inst[25:20]};
                    else            w_imm = {{(XLEN-5){1'b0}}, in_inst[24:20]};
                end else begin
                    w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
                end
            end
            OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                w_fmt = FMT_I;
                w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
            end
            OP_STORE: begin
                w_fmt = FMT_S;
                w_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OP_BRANCH: begin
                w_fmt = FMT_B;
                w_imm = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                         in_inst[30:25], in_inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                w_fmt = FMT_U;
                w_imm = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
            end
            OP_JAL: begin
                w_fmt = FMT_J;
                w_imm = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                         in_inst[20], in_inst[30:21], 1'b0};
            end
            OP_REG: begin
                w_fmt = FMT_NONE;
            end
            default: begin
                w_fmt     = FMT_NONE;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_entry         = '0;
        w_entry.imm     = w_imm;
        w_entry.fmt     = w_fmt;
        w_entry.illegal = w_illegal;
        w_entry.pc      = in_pc;
        w_entry.target  = in_pc + w_imm;
    end

    assign w_accept   = in_valid && r_in_ready;
    assign w_out_load = !r_out_valid || out_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out        <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (w_out_load) begin
            r_in_ready <= 1'b1;
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) r_out <= w_entry;
            end
        end else if (w_accept) begin
            // Output is stalled: park the new entry and stop accepting.
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    // NOTE: skid payload carries no reset; r_skid_valid alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (w_accept && !w_out_load) r_skid <= w_entry;
    end

`ifdef IMM_GEN_STATS_EN
    logic [31:0] r_illegal_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out.illegal) begin
            r_illegal_cnt <= r_illegal_cnt + 32'd1;
        end
    end

    assign illegal_cnt = r_illegal_cnt;
`endif

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_imm     = r_out.imm;
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.illegal;
    assign out_pc      = r_out.pc;
    assign out_target  = r_out.target;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage (XLEN=32 and XLEN=64 instances).
// Stats checks compile in when IMM_GEN_STATS_EN is defined.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_pc;
    logic [31:0] out_target;

    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_inst64;
    logic [63:0] in_pc64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        out_illegal64;
    logic [63:0] out_pc64;
    logic [63:0] out_target64;

`ifdef IMM_GEN_STATS_EN
    logic [31:0] illegal_cnt;
    logic [31:0] illegal_cnt64;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal),
        .out_pc      (out_pc),
        .out_target  (out_target)
`ifdef IMM_GEN_STATS_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    imm_gen_stage #(.XLEN(64)) u_dut64 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush64),
        .in_valid    (in_valid64),
        .in_ready    (in_ready64),
        .in_inst     (in_inst64),
        .in_pc       (in_pc64),
        .out_valid   (out_valid64),
        .out_ready   (out_ready64),
        .out_imm     (out_imm64),
        .out_fmt     (out_fmt64),
        .out_illegal (out_illegal64),
        .out_pc      (out_pc64),
        .out_target  (out_target64)
`ifdef IMM_GEN_STATS_EN
        ,
        .illegal_cnt (illegal_cnt64)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge, so samples taken there are clear of the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry with out_ready high; it must be on the outputs right after the accepting edge.
    task automatic send_chk(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [2:0] fmt, input logic ill,
                            input logic [31:0] tgt);
        in_valid  = 1'b1;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, ".valid"},  out_valid,   1'b1);
        check({tag, ".imm"},    out_imm,     imm);
        check({tag, ".fmt"},    out_fmt,     fmt);
        check({tag, ".ill"},    out_illegal, ill);
        check({tag, ".pc"},     out_pc,      pc);
        check({tag, ".target"}, out_target,  tgt);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        flush64 = 1'b0; in_valid64 = 1'b0; in_inst64 = '0; in_pc64 = '0; out_ready64 = 1'b0;

        // Reset state
        step(); step();
        check("rst.in_ready",  in_ready,    1'b0);
        check("rst.out_valid", out_valid,   1'b0);
        check("rst.imm",       out_imm,     32'h0);
        check("rst.fmt",       out_fmt,     3'd0);
        check("rst.ill",       out_illegal, 1'b0);
        check("rst.pc",        out_pc,      32'h0);
        check("rst.target",    out_target,  32'h0);
        rst = 1'b0;
        step();
        check("rst.in_ready_up", in_ready,  1'b1);
        check("rst.empty",       out_valid, 1'b0);

        // Decode vectors, one per cycle with out_ready high
        send_chk("addi_m1",  32'hFFF00093, 32'h0000_0200, 32'hFFFF_FFFF, 3'd1, 1'b0, 32'h0000_01FF);
        send_chk("sw_m8",    32'hFE20AC23, 32'h0000_0300, 32'hFFFF_FFF8, 3'd2, 1'b0, 32'h0000_02F8);
        send_chk("jal_m4",   32'hFFDFF06F, 32'h0000_0100, 32'hFFFF_FFFC, 3'd5, 1'b0, 32'h0000_00FC);
        send_chk("beq_p8",   32'h00000463, 32'h0000_0100, 32'h0000_0008, 3'd3, 1'b0, 32'h0000_0108);
        send_chk("srai_3",   32'h4030D093, 32'h0000_0010, 32'h0000_0003, 3'd1, 1'b0, 32'h0000_0013);
        send_chk("srai64_32",32'h4210D093, 32'h0000_0010, 32'h0000_0001, 3'd1, 1'b0, 32'h0000_0011);
        send_chk("slli_31",  32'h01F09093, 32'h0000_0000, 32'h0000_001F, 3'd1, 1'b0, 32'h0000_001F);
        send_chk("lui",      32'h123450B7, 32'h0000_0004, 32'h1234_5000, 3'd4, 1'b0, 32'h1234_5004);
        send_chk("auipc_wr", 32'hFFFFF117, 32'h0000_2000, 32'hFFFF_F000, 3'd4, 1'b0, 32'h0000_1000);
        send_chk("lw_min",   32'h8000A083, 32'h0000_1000, 32'hFFFF_F800, 3'd1, 1'b0, 32'h0000_0800);
        send_chk("add_none", 32'h002081B3, 32'h0000_0040, 32'h0000_0000, 3'd0, 1'b0, 32'h0000_0040);
        send_chk("illegal",  32'h00000000, 32'h0000_0080, 32'h0000_0000, 3'd0, 1'b1, 32'h0000_0080);
        step();
        check("drain.empty", out_valid, 1'b0);

        // Backpressure: out_ready low for three edges while four entries are offered
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h10; out_ready = 1'b0;
        step();
        check("bp.e1_out",   out_imm,  32'd1);
        check("bp.ready1",   in_ready, 1'b1);
        in_inst = 32'h00200093; in_pc = 32'h20;
        step();
        check("bp.ready_fall", in_ready, 1'b0);
        check("bp.stable1",    out_imm,  32'd1);
        in_inst = 32'h00300093; in_pc = 32'h30;
        step();
        check("bp.still_low", in_ready,  1'b0);
        check("bp.stable2",   out_imm,   32'd1);
        check("bp.stable_pc", out_pc,    32'h10);
        out_ready = 1'b1;
        step();
        check("bp.e2_out",   out_imm,  32'd2);
        check("bp.e2_pc",    out_pc,   32'h20);
        check("bp.ready_up", in_ready, 1'b1);
        step();
        check("bp.e3_out",   out_imm,  32'd3);
        in_inst = 32'h00400093; in_pc = 32'h40;
        step();
        in_valid = 1'b0;
        check("bp.e4_out",   out_imm,   32'd4);
        check("bp.e4_valid", out_valid, 1'b1);
        step();
        check("bp.drained",  out_valid, 1'b0);

        // Flush with two entries held and a third offered
        in_valid = 1'b1; in_inst = 32'h00500093; out_ready = 1'b0;
        step();
        in_inst = 32'h00600093;
        step();
        check("fl.full", in_ready, 1'b0);
        in_inst = 32'h00700093;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl.out_valid", out_valid, 1'b0);
        check("fl.in_ready",  in_ready,  1'b1);
        out_ready = 1'b1;
        step();
        check("fl.no_skid", out_valid, 1'b0);

        // Flush beats a same-cycle acceptance into an empty buffer
        in_valid = 1'b1; in_inst = 32'h00800093; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl.drop_accept", out_valid, 1'b0);
        send_chk("post_flush", 32'h00900093, 32'h0000_0050, 32'h0000_0009, 3'd1, 1'b0, 32'h0000_0059);

        // Reset aborts held and skidded entries
        in_valid = 1'b1; in_inst = 32'h00A00093; out_ready = 1'b0;
        step();
        in_inst = 32'h00B00093;
        step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        check("rst2.out_valid", out_valid, 1'b0);
        check("rst2.in_ready",  in_ready,  1'b0);
        check("rst2.imm",       out_imm,   32'h0);
        check("rst2.pc",        out_pc,    32'h0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        check("rst2.ready_up", in_ready,  1'b1);
        check("rst2.no_skid",  out_valid, 1'b0);

`ifdef IMM_GEN_STATS_EN
        // Illegal counter: two delivered, one flushed
        check("cnt.reset", illegal_cnt, 32'd0);
        send_chk("ill_a", 32'h00000000, 32'h0000_0A00, 32'h0, 3'd0, 1'b1, 32'h0000_0A00);
        send_chk("ill_b", 32'h00000000, 32'h0000_0B00, 32'h0, 3'd0, 1'b1, 32'h0000_0B00);
        step();
        check("cnt.two", illegal_cnt, 32'd2);
        in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h0C00; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("cnt.c_ill", out_illegal, 1'b1);
        check("cnt.c_imm", out_imm,     32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0; out_ready = 1'b1;
        step();
        check("cnt.after_flush", illegal_cnt, 32'd2);
`endif

        // XLEN=64 instance
        in_valid64 = 1'b1; in_inst64 = 32'hFFF00093; in_pc64 = 64'h1000; out_ready64 = 1'b1;
        step();
        check("x64.addi_imm",    out_imm64,    64'hFFFF_FFFF_FFFF_FFFF);
        check("x64.addi_target", out_target64, 64'h0000_0000_0000_0FFF);
        check("x64.addi_fmt",    out_fmt64,    3'd1);
        in_inst64 = 32'h4210D093;
        step();
        check("x64.srai_33", out_imm64, 64'd33);
        in_inst64 = 32'hFFDFF06F; in_pc64 = 64'h100;
        step();
        in_valid64 = 1'b0;
        check("x64.jal_imm",    out_imm64,    64'hFFFF_FFFF_FFFF_FFFC);
        check("x64.jal_target", out_target64, 64'h0000_0000_0000_00FC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
